// File: rtl/counter_0to19.sv
// counter_0to19 -- BCD up/down counter over 0..19 with a two-digit
// multiplexed 7-segment display driver.
//
// Parameters:
//   SCAN_DIV    clk cycles each display digit is held (legal 1..65535)
//   SEG_ACT_LOW 1 = seg/dig_sel active-low (common anode), 0 = active-high
//
// Ports:
//   clk      system clock (single domain, shared with the div_100 divider)
//   rst      synchronous active-high reset
//   div_clk  count strobe level from div_100; a rising edge is one tick
//   en       count enable, sampled at the tick edge
//   up       direction (1 = up, 0 = down), sampled at the tick edge
//   tens     BCD tens digit (0..1)
//   ones     BCD ones digit (0..9)
//   wrap     one-clk pulse after a 19->0 or 0->19 transition
//   seg      registered segment drive, {g,f,e,d,c,b,a}
//   dig_sel  registered digit enable, bit0 = ones, bit1 = tens
module counter_0to19 #(
  parameter int unsigned SCAN_DIV    = 4,
  parameter bit          SEG_ACT_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       div_clk,
  input  logic       en,
  input  logic       up,
  output logic       tens,
  output logic [3:0] ones,
  output logic       wrap,
  output logic [6:0] seg,
  output logic [1:0] dig_sel
);

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  // Inactive drive levels; XOR with these converts active-high to board levels.
  localparam logic [6:0]  SEG_OFF   = {7{SEG_ACT_LOW}};
  localparam logic [1:0]  DIG_OFF   = {2{SEG_ACT_LOW}};

  typedef enum logic {
    PTR_ONES = 1'b0,
    PTR_TENS = 1'b1
  } ptr_t;

  ptr_t        ptr_q, ptr_d;
  logic        div_prev;
  logic        tick;
  logic [15:0] scan_cnt;
  logic        scan_last;
  logic        tens_d;
  logic [3:0]  ones_d;
  logic        wrap_d;
  logic [3:0]  digit;
  logic        blank;
  logic [6:0]  seg_on;
  logic [1:0]  dig_on;

  // ---------------------------------------------------------------------
  // Strobe edge detect. div_prev follows div_clk even in reset so that a
  // strobe already high at release does not produce a spurious tick.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    div_prev <= div_clk;
  end

  always_comb begin
    tick = div_clk & ~div_prev;
  end

  // ---------------------------------------------------------------------
  // BCD count next-state
  // ---------------------------------------------------------------------
  always_comb begin
    tens_d = tens;
    ones_d = ones;
    wrap_d = 1'b0;
    if (tick && en) begin
      if (up) begin
        if (ones >= 4'd9) begin
          ones_d = 4'd0;
          if (tens) begin
            tens_d = 1'b0;
            wrap_d = 1'b1;
          end else begin
            tens_d = 1'b1;
          end
        end else begin
          ones_d = ones + 4'd1;
        end
      end else begin
        if (ones == 4'd0) begin
          ones_d = 4'd9;
          if (tens) begin
            tens_d = 1'b0;
          end else begin
            tens_d = 1'b1;
            wrap_d = 1'b1;
          end
        end else if (ones > 4'd9) begin
          ones_d = 4'd9;
        end else begin
          ones_d = ones - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tens <= 1'b0;
      ones <= '0;
      wrap <= 1'b0;
    end else begin
      tens <= tens_d;
      ones <= ones_d;
      wrap <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------
  // Display scan: hold each digit SCAN_DIV clocks, then swap.
  // ---------------------------------------------------------------------
  always_comb begin
    scan_last = (scan_cnt == SCAN_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
    end else if (scan_last) begin
      scan_cnt <= '0;
    end else begin
      scan_cnt <= scan_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= PTR_ONES;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (scan_last) begin
      ptr_d = (ptr_q == PTR_ONES) ? PTR_TENS : PTR_ONES;
    end
  end

  // ---------------------------------------------------------------------
  // Digit select and 7-segment decode (active-high internally)
  // ---------------------------------------------------------------------
  always_comb begin
    digit  = ones;
    blank  = 1'b0;
    dig_on = 2'b01;
    if (ptr_q == PTR_TENS) begin
      digit  = {3'b000, tens};
      blank  = ~tens;   // leading-zero blanking; digit stays selected
      dig_on = 2'b10;
    end
  end

  always_comb begin
    seg_on = 7'h00;
    if (!blank) begin
      case (digit)
        4'd0:    seg_on = 7'h3F;
        4'd1:    seg_on = 7'h06;
        4'd2:    seg_on = 7'h5B;
        4'd3:    seg_on = 7'h4F;
        4'd4:    seg_on = 7'h66;
        4'd5:    seg_on = 7'h6D;
        4'd6:    seg_on = 7'h7D;
        4'd7:    seg_on = 7'h07;
        4'd8:    seg_on = 7'h7F;
        4'd9:    seg_on = 7'h6F;
        default: seg_on = 7'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg     <= SEG_OFF;
      dig_sel <= DIG_OFF;
    end else begin
      seg     <= seg_on ^ SEG_OFF;
      dig_sel <= dig_on ^ DIG_OFF;
    end
  end

endmodule
